// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM slot timer.
//   TDM_TIME_W / TDM_SLOT_W : default widths of the slot index and slot-select fields
//   slot_cfg_t              : one TX/RX slot configuration (active or pending)
//   tdm_state_t             : frame timer state
//   slot_hit()              : true when an enabled slot select matches the current slot
package tdm_pkg;

  localparam int TDM_TIME_W = 7;
  localparam int TDM_SLOT_W = 8;

  typedef struct packed {
    logic [TDM_SLOT_W-1:0] tx_slot;
    logic [TDM_SLOT_W-1:0] rx_slot;
    logic                  tx_en;
    logic                  rx_en;
  } slot_cfg_t;

  typedef enum logic {
    TDM_IDLE = 1'b0,
    TDM_RUN  = 1'b1
  } tdm_state_t;

  // The slot index is zero-extended by the caller, so a select value beyond
  // the last slot of the frame simply never matches.
  function automatic logic slot_hit(input logic                  en,
                                    input logic [TDM_SLOT_W-1:0] slot,
                                    input logic [TDM_SLOT_W-1:0] slot_time);
    return en && (slot == slot_time);
  endfunction

endpackage

// File: rtl/tdm_slot_prescaler.sv
// Divide-by-CYCLES_PER_SLOT counter that paces the slot index.
//   SYS_CLK : clock
//   RST     : asynchronous active-high reset
//   CLEAR   : synchronous clear, holds the count at 0
//   TC      : high while the count sits on its terminal value (CYCLES_PER_SLOT-1)
module tdm_slot_prescaler #(
  parameter int CYCLES_PER_SLOT = 16
) (
  input  logic SYS_CLK,
  input  logic RST,
  input  logic CLEAR,
  output logic TC
);

  localparam int CNT_W = $clog2(CYCLES_PER_SLOT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_SLOT - 1);

  logic [CNT_W-1:0] count_q;

  assign TC = (count_q == LAST);

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else if (CLEAR || TC) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_slot_timer.sv
// Master TDM frame timer.
// Produces the slot index TIME, the active TX/RX slot configuration for the
// gated-clock generator, slot/frame start pulses and registered per-slot clock
// enables. New slot configurations arrive over a valid/ready port and are only
// applied on frame boundaries (or straight away while idle).
//   SYS_CLK, RST                 : clock, asynchronous active-high reset
//   ENABLE                       : 1 runs the frame timer, 0 holds it idle
//   CFG_VALID/CFG_READY          : configuration handshake
//   CFG_TX_SLOT/CFG_RX_SLOT      : requested slot selects
//   CFG_TXSLOT_EN/CFG_RXSLOT_EN  : requested slot enables
//   TIME                         : current slot index
//   TX_SLOT/RX_SLOT/TXSLOT_EN/RXSLOT_EN : active configuration
//   SLOT_START/FRAME_START       : first cycle of every slot / of slot 0
//   TX_CE/RX_CE                  : high for every cycle of the active TX/RX slot
// SLOT_W must match tdm_pkg::TDM_SLOT_W, which sizes the configuration struct.
module tdm_slot_timer
  import tdm_pkg::*;
#(
  parameter int TIME_W          = TDM_TIME_W,
  parameter int SLOT_W          = TDM_SLOT_W,
  parameter int NUM_SLOTS       = 128,
  parameter int CYCLES_PER_SLOT = 16
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [SLOT_W-1:0] CFG_TX_SLOT,
  input  logic [SLOT_W-1:0] CFG_RX_SLOT,
  input  logic              CFG_TXSLOT_EN,
  input  logic              CFG_RXSLOT_EN,
  output logic [TIME_W-1:0] TIME,
  output logic [SLOT_W-1:0] TX_SLOT,
  output logic [SLOT_W-1:0] RX_SLOT,
  output logic              TXSLOT_EN,
  output logic              RXSLOT_EN,
  output logic              SLOT_START,
  output logic              FRAME_START,
  output logic              TX_CE,
  output logic              RX_CE
);

  localparam logic [TIME_W-1:0] LAST_SLOT = TIME_W'(NUM_SLOTS - 1);

  tdm_state_t        state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  slot_cfg_t         active_q, active_d;
  slot_cfg_t         pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic              slot_start_q, slot_start_d;
  logic              frame_start_q, frame_start_d;
  logic              tx_ce_q, tx_ce_d;
  logic              rx_ce_q, rx_ce_d;

  logic              running;
  logic              presc_clear;
  logic              presc_tc;
  logic              boundary;
  logic              xfer;
  slot_cfg_t         cfg_in;

  // The prescaler only advances while the timer runs and stays enabled, so it
  // reads 0 on the first RUN cycle after IDLE.
  assign running     = (state_q == TDM_RUN);
  assign presc_clear = !(running && ENABLE);

  tdm_slot_prescaler #(
    .CYCLES_PER_SLOT(CYCLES_PER_SLOT)
  ) u_prescaler (
    .SYS_CLK(SYS_CLK),
    .RST    (RST),
    .CLEAR  (presc_clear),
    .TC     (presc_tc)
  );

  assign xfer   = CFG_VALID && !pend_v_q;
  assign cfg_in = '{tx_slot: CFG_TX_SLOT, rx_slot: CFG_RX_SLOT,
                    tx_en: CFG_TXSLOT_EN, rx_en: CFG_RXSLOT_EN};

  // Everything below computes the values the registers take at the next edge,
  // so pulses and clock enables come out registered and aligned with TIME.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    time_d        = '0;
    active_d      = active_q;
    pend_d        = pend_q;
    pend_v_d      = pend_v_q;
    slot_start_d  = 1'b0;
    frame_start_d = 1'b0;
    boundary      = 1'b0;

    case (state_q)
      TDM_IDLE: if (ENABLE)  state_d = TDM_RUN;
      TDM_RUN:  if (!ENABLE) state_d = TDM_IDLE;
      default:               state_d = TDM_IDLE;
    endcase

    if (running && ENABLE) begin
      if (presc_tc) time_d = (time_q == LAST_SLOT) ? '0 : time_q + 1'b1;
      else          time_d = time_q;
    end

    // Next cycle is a slot start either on RUN entry or after terminal count.
    slot_start_d  = (state_d == TDM_RUN) && (!running || presc_tc);
    frame_start_d = slot_start_d && (time_d == '0);

    // A configuration may only become active where no slot is in progress:
    // the first cycle of a frame, or any IDLE cycle.
    boundary = (state_d == TDM_IDLE) || frame_start_d;

    if (xfer && boundary) begin
      active_d = cfg_in;
    end else if (xfer) begin
      pend_d   = cfg_in;
      pend_v_d = 1'b1;
    end else if (pend_v_q && boundary) begin
      active_d = pend_q;
      pend_v_d = 1'b0;
    end

    tx_ce_d = (state_d == TDM_RUN) &&
              slot_hit(active_d.tx_en, active_d.tx_slot, TDM_SLOT_W'(time_d));
    rx_ce_d = (state_d == TDM_RUN) &&
              slot_hit(active_d.rx_en, active_d.rx_slot, TDM_SLOT_W'(time_d));
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the pending shadow is cleared along with the active config so a
      // half-finished handshake cannot surface after reset.
      state_q       <= TDM_IDLE;
      time_q        <= '0;
      active_q      <= '0;
      pend_q        <= '0;
      pend_v_q      <= 1'b0;
      slot_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      tx_ce_q       <= 1'b0;
      rx_ce_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values of the previous cycle, independent of statement order.
      state_q       <= state_d;
      time_q        <= time_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_v_q      <= pend_v_d;
      slot_start_q  <= slot_start_d;
      frame_start_q <= frame_start_d;
      tx_ce_q       <= tx_ce_d;
      rx_ce_q       <= rx_ce_d;
    end
  end

  assign CFG_READY   = !pend_v_q;
  assign TIME        = time_q;
  assign TX_SLOT     = active_q.tx_slot;
  assign RX_SLOT     = active_q.rx_slot;
  assign TXSLOT_EN   = active_q.tx_en;
  assign RXSLOT_EN   = active_q.rx_en;
  assign SLOT_START  = slot_start_q;
  assign FRAME_START = frame_start_q;
  assign TX_CE       = tx_ce_q;
  assign RX_CE       = rx_ce_q;

endmodule

// File: tb/tb_tdm_slot_timer.sv
// Self-checking bench for tdm_slot_timer (NUM_SLOTS=128, CYCLES_PER_SLOT=4).
// A cycle-level model tracks how many cycles the timer has been running and
// derives slot index, pulses and clock enables arithmetically from that count.
module tb_tdm_slot_timer;

  localparam int NS  = 128;
  localparam int CPS = 4;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       enable  = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_tx_slot = '0;
  logic [7:0] cfg_rx_slot = '0;
  logic       cfg_txslot_en = 1'b0;
  logic       cfg_rxslot_en = 1'b0;
  logic [6:0] slot_time;
  logic [7:0] tx_slot, rx_slot;
  logic       txslot_en, rxslot_en;
  logic       slot_start, frame_start;
  logic       tx_ce, rx_ce;

  int n_checks = 0;
  int n_fail   = 0;

  tdm_slot_timer #(
    .TIME_W(7), .SLOT_W(8), .NUM_SLOTS(NS), .CYCLES_PER_SLOT(CPS)
  ) dut (
    .SYS_CLK      (sys_clk),
    .RST          (rst),
    .ENABLE       (enable),
    .CFG_VALID    (cfg_valid),
    .CFG_READY    (cfg_ready),
    .CFG_TX_SLOT  (cfg_tx_slot),
    .CFG_RX_SLOT  (cfg_rx_slot),
    .CFG_TXSLOT_EN(cfg_txslot_en),
    .CFG_RXSLOT_EN(cfg_rxslot_en),
    .TIME         (slot_time),
    .TX_SLOT      (tx_slot),
    .RX_SLOT      (rx_slot),
    .TXSLOT_EN    (txslot_en),
    .RXSLOT_EN    (rxslot_en),
    .SLOT_START   (slot_start),
    .FRAME_START  (frame_start),
    .TX_CE        (tx_ce),
    .RX_CE        (rx_ce)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_run = 1'b0;
  int m_k   = 0;        // cycles since RUN entry
  int m_tx_slot = 0, m_rx_slot = 0;
  bit m_tx_en = 1'b0, m_rx_en = 1'b0;
  bit m_pend_v = 1'b0;
  int p_tx_slot = 0, p_rx_slot = 0;
  bit p_tx_en = 1'b0, p_rx_en = 1'b0;
  bit m_xfer, m_boundary;

  initial forever begin
    @(posedge sys_clk or posedge rst);
    if (rst) begin
      m_run = 0; m_k = 0; m_pend_v = 0;
      m_tx_slot = 0; m_rx_slot = 0; m_tx_en = 0; m_rx_en = 0;
      p_tx_slot = 0; p_rx_slot = 0; p_tx_en = 0; p_rx_en = 0;
    end else begin
      m_xfer = cfg_valid && !m_pend_v;
      if (!m_run) begin
        if (enable) begin m_run = 1; m_k = 0; end
      end else if (enable) begin
        m_k++;
      end else begin
        m_run = 0; m_k = 0;
      end
      m_boundary = !m_run || (m_k % (CPS * NS) == 0);
      if (m_xfer && m_boundary) begin
        m_tx_slot = int'(cfg_tx_slot); m_rx_slot = int'(cfg_rx_slot);
        m_tx_en = cfg_txslot_en; m_rx_en = cfg_rxslot_en;
      end else if (m_xfer) begin
        p_tx_slot = int'(cfg_tx_slot); p_rx_slot = int'(cfg_rx_slot);
        p_tx_en = cfg_txslot_en; p_rx_en = cfg_rxslot_en;
        m_pend_v = 1;
      end else if (m_pend_v && m_boundary) begin
        m_tx_slot = p_tx_slot; m_rx_slot = p_rx_slot;
        m_tx_en = p_tx_en; m_rx_en = p_rx_en;
        m_pend_v = 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  int e_time;
  bit e_ss;
  always @(negedge sys_clk) begin
    e_time = m_run ? (m_k / CPS) % NS : 0;
    e_ss   = m_run && (m_k % CPS == 0);
    check("m_time",        slot_time,   e_time);
    check("m_slot_start",  slot_start,  e_ss);
    check("m_frame_start", frame_start, e_ss && e_time == 0);
    check("m_tx_ce",       tx_ce,       m_run && m_tx_en && m_tx_slot == e_time);
    check("m_rx_ce",       rx_ce,       m_run && m_rx_en && m_rx_slot == e_time);
    check("m_tx_slot",     tx_slot,     m_tx_slot);
    check("m_rx_slot",     rx_slot,     m_rx_slot);
    check("m_txslot_en",   txslot_en,   m_tx_en);
    check("m_rxslot_en",   rxslot_en,   m_rx_en);
    check("m_cfg_ready",   cfg_ready,   !m_pend_v);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic send_cfg(input int tx, input int rx, input bit txe, input bit rxe);
    int w;
    w = 0;
    while (!cfg_ready && w < 2000) begin
      step(1);
      w++;
    end
    check("ready_before_send", cfg_ready, 1);
    cfg_tx_slot = 8'(tx); cfg_rx_slot = 8'(rx);
    cfg_txslot_en = txe; cfg_rxslot_en = rxe;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  int tx_hi, rx_hi;

  initial begin
    // 1. reset and basic frame timing
    step(3);
    check("rst_time", slot_time, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_frame_start", frame_start, 0);
    check("rst_tx_ce", tx_ce, 0);
    rst = 1'b0;
    step(2);
    enable = 1'b1;
    step(1);                          // RUN cycle 0
    check("run0_frame_start", frame_start, 1);
    check("run0_slot_start", slot_start, 1);
    step(4);                          // cycle 4
    check("c4_time", slot_time, 1);
    check("c4_frame_start", frame_start, 0);
    step(504);                        // cycle 508
    check("c508_time", slot_time, 127);
    step(4);                          // cycle 512
    check("c512_time", slot_time, 0);
    check("c512_frame_start", frame_start, 1);

    // 2. config while idle
    enable = 1'b0;
    step(1);
    check("idle_time", slot_time, 0);
    send_cfg(5, 0, 1, 0);
    check("idle_cfg_tx_slot", tx_slot, 5);
    check("idle_cfg_ready", cfg_ready, 1);
    enable = 1'b1;
    step(1);                          // frame 0 cycle 0
    step(19);
    check("c19_tx_ce", tx_ce, 0);
    step(1);
    check("c20_tx_ce", tx_ce, 1);
    step(3);
    check("c23_tx_ce", tx_ce, 1);
    step(1);                          // cycle 24
    check("c24_tx_ce", tx_ce, 0);

    // 3. config while running, TIME=40
    step(136);                        // cycle 160
    check("c160_time", slot_time, 40);
    send_cfg(9, 0, 1, 0);             // now cycle 161
    check("pend_ready", cfg_ready, 0);
    step(350);                        // cycle 511
    check("c511_ready", cfg_ready, 0);
    check("c511_tx_slot", tx_slot, 5);
    step(1);                          // cycle 512, next frame
    check("f1_frame_start", frame_start, 1);
    check("f1_ready", cfg_ready, 1);
    check("f1_tx_slot", tx_slot, 9);
    step(36);                         // slot 9
    check("f1_slot9_tx_ce", tx_ce, 1);

    // 4. out-of-range TX, RX on slot 3
    send_cfg(200, 3, 1, 1);           // cycle 549, applies at 1024
    step(475);                        // cycle 1024
    check("f2_tx_slot", tx_slot, 200);
    tx_hi = 0; rx_hi = 0;
    for (int i = 0; i < 2 * NS * CPS; i++) begin
      if (tx_ce) tx_hi++;
      if (rx_ce) rx_hi++;
      step(1);
    end                               // cycle 2048, frame start
    check("oor_tx_ce_count", tx_hi, 0);
    check("oor_rx_ce_count", rx_hi, 8);
    send_cfg(3, 3, 1, 1);             // on FRAME_START: waits a whole frame
    check("fs_xfer_tx_slot", tx_slot, 200);
    step(511);                        // cycle 2560
    check("shared_tx_slot", tx_slot, 3);
    step(12);                         // slot 3
    check("shared_tx_ce", tx_ce, 1);
    check("shared_rx_ce", rx_ce, 1);

    // 5. enable drop with pending config at TIME=60
    send_cfg(7, 8, 1, 1);             // cycle 2573
    step(227);                        // cycle 2800
    check("c2800_time", slot_time, 60);
    check("c2800_ready", cfg_ready, 0);
    enable = 1'b0;
    step(1);
    check("drop_time", slot_time, 0);
    check("drop_tx_ce", tx_ce, 0);
    check("drop_rx_ce", rx_ce, 0);
    check("drop_tx_slot", tx_slot, 7);
    check("drop_rx_slot", rx_slot, 8);
    check("drop_ready", cfg_ready, 1);

    // 6. asynchronous reset mid-slot
    send_cfg(5, 0, 1, 0);
    enable = 1'b1;
    step(1);                          // cycle 0
    step(21);                         // cycle 21, inside slot 5
    check("pre_rst_tx_ce", tx_ce, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_time", slot_time, 0);
    check("arst_tx_ce", tx_ce, 0);
    check("arst_tx_slot", tx_slot, 0);
    check("arst_txslot_en", txslot_en, 0);
    check("arst_ready", cfg_ready, 1);
    enable = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);
    check("post_rst_tx_slot", tx_slot, 0);
    check("post_rst_rx_slot", rx_slot, 0);
    check("post_rst_txslot_en", txslot_en, 0);
    check("post_rst_rxslot_en", rxslot_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
